// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mc_pkg
// Brief   : Shared encodings for the multicycle main control FSM.
// Rev     : 1.0  initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_J     = 6'd2;

  localparam logic [1:0] ALUSRCB_B     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_main_control_if.sv
`default_nettype none
// ============================================================================
// Module  : mc_main_control_if
// Brief   : Control-to-datapath bundle: opcode/ready in, enables/selects out.
// Rev     : 1.0  initial release
// ============================================================================
interface mc_main_control_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       pcwritecond;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       aluop1;
  logic       aluop0;
  logic       illegal;

  modport master (
    input  op, mem_ready,
    output pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, illegal
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
           aluop1, aluop0, illegal
  );
endinterface
`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module  : mc_ctrl_decode
// Brief   : Combinational state-to-control output table.
// Rev     : 1.0  initial release
// ============================================================================
module mc_ctrl_decode
  import mc_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // IR and PC only advance once the instruction word has actually arrived
        ctrl_o.memread  = 1'b1;
        ctrl_o.alusrcb  = ALUSRCB_FOUR;
        ctrl_o.pcsource = PCSRC_ALU;
        ctrl_o.aluop    = ALUOP_ADD;
        ctrl_o.irwrite  = mem_ready_i;
        ctrl_o.pcwrite  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alusrcb = ALUSRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
        ctrl_o.illegal = !op_known(op_i);
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = ALUSRCB_B;
        ctrl_o.aluop   = ALUOP_FUNC;
      end
      S_RWB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.alusrcb     = ALUSRCB_B;
        ctrl_o.aluop       = ALUOP_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsource    = PCSRC_ALUOUT;
      end
      S_ADDIWB: begin
        ctrl_o.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.pcsource = PCSRC_JUMP;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mc_main_control.sv
`default_nettype none
// ============================================================================
// Module  : mc_main_control
// Brief   : Multicycle main control FSM with memory ready handshake.
// Rev     : 1.0  initial release
// ============================================================================
module mc_main_control
  import mc_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset_n,
  mc_main_control_if.master         bus
);

  state_e state_q;
  state_e state_d;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // A non-memory opcode here can only come from a corrupted IR; recover via fetch
        if      (bus.op == OP_LW) state_d = S_MEMRD;
        else if (bus.op == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .op_i        (bus.op),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (w_ctrl)
  );

  assign bus.pcwrite     = w_ctrl.pcwrite;
  assign bus.pcwritecond = w_ctrl.pcwritecond;
  assign bus.iord        = w_ctrl.iord;
  assign bus.memread     = w_ctrl.memread;
  assign bus.memwrite    = w_ctrl.memwrite;
  assign bus.irwrite     = w_ctrl.irwrite;
  assign bus.memtoreg    = w_ctrl.memtoreg;
  assign bus.regdst      = w_ctrl.regdst;
  assign bus.regwrite    = w_ctrl.regwrite;
  assign bus.alusrca     = w_ctrl.alusrca;
  assign bus.alusrcb     = w_ctrl.alusrcb;
  assign bus.pcsource    = w_ctrl.pcsource;
  assign bus.aluop1      = w_ctrl.aluop[1];
  assign bus.aluop0      = w_ctrl.aluop[0];
  assign bus.illegal     = w_ctrl.illegal;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_control.sv
`default_nettype none
// ============================================================================
// Module  : tb_mc_main_control
// Brief   : Table-driven bench for the multicycle main control FSM.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mc_main_control;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  mc_main_control_if bus ();

  mc_main_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,memtoreg,regdst,
  //  regwrite,alusrca,alusrcb[1:0],pcsource[1:0],aluop1,aluop0,illegal}
  function automatic logic [16:0] mk(
    input logic pcw, input logic pcwc, input logic iord, input logic mr,
    input logic mw, input logic irw, input logic m2r, input logic rd,
    input logic rw, input logic asa, input logic [1:0] asb,
    input logic [1:0] pcs, input logic [1:0] aop, input logic ill);
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, pcs, aop, ill};
  endfunction

  function automatic logic [16:0] actual();
    return {bus.pcwrite, bus.pcwritecond, bus.iord, bus.memread, bus.memwrite,
            bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca,
            bus.alusrcb, bus.pcsource, bus.aluop1, bus.aluop0, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [16:0] exp);
    logic [16:0] act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [16:0] exp;
  } vec_t;

  logic [16:0] E_IDLE, E_FETCH, E_FSTALL, E_DEC, E_DECILL, E_MEMADR, E_MEMRD,
               E_MEMWB, E_MEMWR, E_EXEC, E_RWB, E_BRANCH, E_ADDIEX, E_ADDIWB,
               E_JUMP;

  // Runs one instruction from a FETCH with ready high, counting cycles until
  // the next instruction fetch completes, plus illegal pulses and writes.
  task automatic measure(input string name, input logic [5:0] op, input int exp_cyc,
                         input int exp_ill, input int exp_wr);
    int n, ill, wr;
    n = 0; ill = 0; wr = 0;
    bus.op = op;
    bus.mem_ready = 1'b1;
    do begin
      @(negedge clk);
      #1;
      n++;
      if (bus.illegal) ill++;
      if (bus.regwrite || bus.memwrite) wr++;
    end while (!bus.irwrite && n < 20);
    check_int({name, "_cycles"}, n, exp_cyc);
    check_int({name, "_illegal"}, ill, exp_ill);
    check_int({name, "_writes"}, wr, exp_wr);
  endtask

  vec_t tbl[37];

  initial begin
    total = 0;
    bad   = 0;
    E_IDLE   = '0;
    E_FETCH  = mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
    E_FSTALL = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    E_DEC    = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    E_DECILL = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1);
    E_MEMADR = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    E_MEMRD  = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_MEMWB  = mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
    E_MEMWR  = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    E_EXEC   = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0);
    E_RWB    = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
    E_BRANCH = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
    E_ADDIEX = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
    E_ADDIWB = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    E_JUMP   = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b10,2'b00,0);

    tbl[0]  = '{6'd0,  1'b1, E_IDLE};
    tbl[1]  = '{6'd35, 1'b1, E_FETCH};
    tbl[2]  = '{6'd35, 1'b1, E_DEC};
    tbl[3]  = '{6'd35, 1'b1, E_MEMADR};
    tbl[4]  = '{6'd35, 1'b1, E_MEMRD};
    tbl[5]  = '{6'd35, 1'b1, E_MEMWB};
    tbl[6]  = '{6'd0,  1'b1, E_FETCH};
    tbl[7]  = '{6'd0,  1'b1, E_DEC};
    tbl[8]  = '{6'd35, 1'b1, E_EXEC};
    tbl[9]  = '{6'd35, 1'b1, E_RWB};
    tbl[10] = '{6'd4,  1'b1, E_FETCH};
    tbl[11] = '{6'd4,  1'b1, E_DEC};
    tbl[12] = '{6'd4,  1'b1, E_BRANCH};
    tbl[13] = '{6'd8,  1'b1, E_FETCH};
    tbl[14] = '{6'd8,  1'b1, E_DEC};
    tbl[15] = '{6'd8,  1'b1, E_ADDIEX};
    tbl[16] = '{6'd8,  1'b1, E_ADDIWB};
    tbl[17] = '{6'd2,  1'b1, E_FETCH};
    tbl[18] = '{6'd2,  1'b1, E_DEC};
    tbl[19] = '{6'd2,  1'b1, E_JUMP};
    tbl[20] = '{6'd63, 1'b1, E_FETCH};
    tbl[21] = '{6'd63, 1'b1, E_DECILL};
    tbl[22] = '{6'd43, 1'b0, E_FSTALL};
    tbl[23] = '{6'd43, 1'b1, E_FETCH};
    tbl[24] = '{6'd43, 1'b1, E_DEC};
    tbl[25] = '{6'd43, 1'b1, E_MEMADR};
    tbl[26] = '{6'd43, 1'b0, E_MEMWR};
    tbl[27] = '{6'd43, 1'b0, E_MEMWR};
    tbl[28] = '{6'd43, 1'b0, E_MEMWR};
    tbl[29] = '{6'd43, 1'b1, E_MEMWR};
    tbl[30] = '{6'd35, 1'b1, E_FETCH};
    tbl[31] = '{6'd35, 1'b0, E_DEC};
    tbl[32] = '{6'd35, 1'b1, E_MEMADR};
    tbl[33] = '{6'd35, 1'b0, E_MEMRD};
    tbl[34] = '{6'd35, 1'b1, E_MEMRD};
    tbl[35] = '{6'd43, 1'b0, E_MEMWB};
    tbl[36] = '{6'd0,  1'b1, E_FETCH};

    reset_n       = 1'b0;
    bus.op        = 6'd0;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("reset_held", E_IDLE);

    for (int i = 0; i < 37; i++) begin
      @(negedge clk);
      bus.op        = tbl[i].op;
      bus.mem_ready = tbl[i].mr;
      if (i == 0) reset_n = 1'b1;
      #1;
      check($sformatf("row%0d", i), tbl[i].exp);
    end

    // lw stalled in MEMRD, then asynchronous reset mid-stall
    @(negedge clk); bus.op = 6'd35; bus.mem_ready = 1'b1; #1;
    check("rst_seq_decode", E_DEC);
    @(negedge clk); #1;
    check("rst_seq_memadr", E_MEMADR);
    @(negedge clk); bus.mem_ready = 1'b0; #1;
    check("rst_seq_memrd", E_MEMRD);
    @(negedge clk); #1;
    check("rst_seq_memrd_stall", E_MEMRD);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_zero", E_IDLE);
    @(posedge clk); #1;
    check("rst_held_zero", E_IDLE);
    @(negedge clk); reset_n = 1'b1; bus.mem_ready = 1'b1; #1;
    check("rst_release_idle", E_IDLE);
    @(negedge clk); #1;
    check("rst_first_fetch", E_FETCH);

    measure("lw",    6'd35, 5, 0, 1);
    measure("sw",    6'd43, 4, 0, 1);
    measure("rtype", 6'd0,  4, 0, 1);
    measure("addi",  6'd8,  4, 0, 1);
    measure("beq",   6'd4,  3, 0, 0);
    measure("j",     6'd2,  3, 0, 0);
    measure("ill",   6'd63, 2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
